// File: rtl/siphash_msg_padder.sv
// Byte-stream front end for the SipHash core: packs bytes into 64-bit words,
// appends the length-tagged final word and sequences the core strobes.
module siphash_msg_padder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        msg_end,
    input  logic        core_ready,
    output logic        core_initalize,
    output logic        core_compress,
    output logic        core_finalize,
    output logic [63:0] core_mi,
    output logic        busy,
    output logic        msg_done
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] INIT       = 4'd1;
    localparam logic [3:0] COLLECT    = 4'd2;
    localparam logic [3:0] COMP       = 4'd3;
    localparam logic [3:0] COMP_WAIT  = 4'd4;
    localparam logic [3:0] LAST       = 4'd5;
    localparam logic [3:0] LAST_WAIT  = 4'd6;
    localparam logic [3:0] FINAL      = 4'd7;
    localparam logic [3:0] FINAL_WAIT = 4'd8;

    logic [3:0]  state;
    logic [2:0]  byte_idx;
    logic [7:0]  len_ctr;
    logic [63:0] word_reg;
    logic        pend_last;
    logic        skip;
    logic        wait_ok;
    logic [63:0] final_word;

    // Unused trailing bytes are already zero because word_reg is cleared per word.
    assign final_word     = {len_ctr, word_reg[55:0]};
    assign wait_ok        = !skip && core_ready;
    assign data_ready     = (state == COLLECT);
    assign core_initalize = (state == INIT) && core_ready;
    assign core_compress  = ((state == COMP) || (state == LAST)) && core_ready;
    assign core_finalize  = (state == FINAL) && core_ready;
    assign busy           = (state != IDLE);
    assign msg_done       = (state == FINAL_WAIT) && wait_ok;

    always_comb begin
        core_mi = 64'h0;
        if (state == COMP)
            core_mi = word_reg;
        else if (state == LAST)
            core_mi = final_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_idx  <= 3'd0;
            len_ctr   <= 8'd0;
            word_reg  <= 64'h0;
            pend_last <= 1'b0;
            skip      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && core_ready)
                        state <= INIT;
                end
                INIT: begin
                    if (core_ready) begin
                        state     <= COLLECT;
                        byte_idx  <= 3'd0;
                        len_ctr   <= 8'd0;
                        word_reg  <= 64'h0;
                        pend_last <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (data_valid) begin
                        word_reg[{byte_idx, 3'b000} +: 8] <= data_in;
                        byte_idx <= byte_idx + 3'd1;
                        len_ctr  <= len_ctr + 8'd1;
                    end
                    // A full word must be compressed before the final word is built.
                    if (data_valid && (byte_idx == 3'd7)) begin
                        state     <= COMP;
                        pend_last <= msg_end;
                    end else if (msg_end) begin
                        state <= LAST;
                    end
                end
                COMP: begin
                    if (core_ready) begin
                        state    <= COMP_WAIT;
                        word_reg <= 64'h0;
                        skip     <= 1'b1;
                    end
                end
                COMP_WAIT: begin
                    if (skip) begin
                        skip <= 1'b0;
                    end else if (core_ready) begin
                        state     <= pend_last ? LAST : COLLECT;
                        pend_last <= 1'b0;
                    end
                end
                LAST: begin
                    if (core_ready) begin
                        state <= LAST_WAIT;
                        skip  <= 1'b1;
                    end
                end
                LAST_WAIT: begin
                    if (skip)
                        skip <= 1'b0;
                    else if (core_ready)
                        state <= FINAL;
                end
                FINAL: begin
                    if (core_ready) begin
                        state <= FINAL_WAIT;
                        skip  <= 1'b1;
                    end
                end
                FINAL_WAIT: begin
                    if (skip)
                        skip <= 1'b0;
                    else if (core_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/siphash_msg_padder.md
Name: siphash_msg_padder

Overview:
- Upstream feeder for the SipHash core.
- Accepts a message as a byte stream and packs the bytes little-endian into 64-bit words.
- Appends the SipHash final word: the trailing bytes, with the message length mod 256 in the top byte.
- Sequences the core's initalize / compress / finalize strobes against its ready output, so the core sees correctly ordered, correctly padded mi words.

Parameters:
- None. Round counts, key and long select are wired directly to the core.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: begin new message (initialise core); ignored unless busy=0
- data_in  in  8  message byte
- data_valid  in  1  data_in valid
- data_ready  out  1  byte accepted when data_valid & data_ready
- msg_end  in  1  end of message; sampled only in COLLECT; a byte accepted in the same cycle belongs to the message
- core_ready  in  1  ready output of core
- core_initalize  out  1  one-cycle strobe to core
- core_compress  out  1  one-cycle strobe to core
- core_finalize  out  1  one-cycle strobe to core
- core_mi  out  64  message word to core; stable while core_compress=1
- busy  out  1  high from accepted start until msg_done
- msg_done  out  1  one-cycle pulse when finalization by core has completed (core_ready high again)

Behaviour:
- Reset (async, high): state IDLE; all outputs 0 except core_mi=0 (busy=0, data_ready=0); byte_idx=0, len_ctr=0, word_reg=0.
- Reset mid-operation aborts the message: no further strobes; the core is not reset by this block.
- Counters and packing:
  - byte_idx 3 bits, len_ctr 8 bits; both increment per accepted byte, len_ctr wraps 255->0.
  - An accepted byte is written to word_reg[8*byte_idx+7 : 8*byte_idx].
- FSM states and transitions:
  - IDLE: start & core_ready -> INIT; start while core_ready=0 is ignored.
  - INIT: core_initalize=1 for exactly one cycle; clear counters and word_reg -> COLLECT. busy=1 from INIT onward.
  - COLLECT:
    - data_ready=1.
    - Byte accepted with byte_idx=7 (and no msg_end) -> COMP.
    - msg_end=1 -> LAST; if a byte is accepted that cycle, it and len_ctr+1 are included.
    - If that byte completes a word (byte_idx=7), go to COMP with a pending-last flag set; after COMP_WAIT, go to LAST.
  - COMP:
    - data_ready=0; wait core_ready=1.
    - Assert core_compress=1 for one cycle with core_mi=word_reg -> COMP_WAIT.
    - Clear word_reg the same edge.
  - COMP_WAIT:
    - Skip one cycle unconditionally (core drops ready the cycle after the strobe).
    - Then wait core_ready=1 -> COLLECT, or -> LAST if pending-last.
  - LAST:
    - Build final word: word_reg with bits [63:56] = len_ctr; unused bytes are 0.
    - For a length that is a multiple of 8, the final word is {len_ctr, 56'h0}.
    - Issue core_compress as in COMP -> LAST_WAIT.
  - LAST_WAIT: one-cycle skip, then wait core_ready=1 -> FINAL.
  - FINAL: core_finalize=1 for one cycle -> FINAL_WAIT.
  - FINAL_WAIT: one-cycle skip, then wait core_ready=1; pulse msg_done=1 -> IDLE; busy=0 next cycle.
- Strobe and data_ready rules:
  - Never more than one of core_initalize/compress/finalize high in a cycle.
  - No strobe is issued while core_ready=0.
  - data_ready=0 in every state except COLLECT.
- start while busy: ignored, no effect.
- msg_end with data_valid=0 in COLLECT: ends the message with no extra byte.
- Empty message: start, then msg_end -> single compress of 0x0000000000000000, then finalize.
- Latency:
  - start -> core_initalize: 1 cycle.
  - 8th byte accepted -> core_compress: 1 cycle if core_ready=1.

Test Plan:
- 15-byte message 0x00..0x0e, core key 0x0f..0x00 (key[127:0]=0x0f0e...00), 2-4 rounds -> compresses 0x0706050403020100 then 0x0f0e0d0c0b0a0908, then finalize; core word0 = 0xa129ca6149be45e5; msg_done once.
- Empty message (start, msg_end next COLLECT cycle) -> exactly one compress with mi=0x0000000000000000, one finalize, msg_done.
- 8 bytes 0x00..0x07, msg_end with 8th byte -> compress 0x0706050403020100, then 0x0800000000000000, then finalize.
- 256 bytes of 0xAA -> 32 compresses of 0xAAAAAAAAAAAAAAAA, then final word 0x0000000000000000 (length wrap), then finalize.
- core_ready held low 10 cycles after a compress -> data_ready stays 0, no second strobe until core_ready=1; assert one strobe max per cycle throughout.
- Assert reset during COLLECT after 5 bytes -> all outputs 0 immediately. A new start then yields the correct first word, with no stale bytes from the aborted message.
